// File: rtl/systolic_array_seq_pkg.sv
// Shared types, default sizes and the saturating adder for the systolic array.
// The saturating adder is only used when SYS_ARRAY_SAT_EN is defined.
package systolic_array_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN
  } sys_fsm_e;

  localparam int ROWS_D   = 4;
  localparam int COLS_D   = 4;
  localparam int DATA_W_D = 8;
  localparam int ACC_W_D  = 32;
  localparam int K_MAX_D  = 256;

  // Operands arrive sign-extended to 64 bits; w must be at most 63.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] x,
    input  logic signed [63:0] y,
    input  int                 w,
    output logic               hit
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = x + y;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    hit = 1'b0;
    if (s > hi) begin
      s   = hi;
      hit = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      hit = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/systolic_array_seq_if.sv
// Operand/result stream bundle of the systolic array.
// master drives operands and result ready; slave is the array.
interface systolic_array_seq_if
  import systolic_array_seq_pkg::*;
#(
  parameter int ROWS   = ROWS_D,
  parameter int COLS   = COLS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int K_MAX  = K_MAX_D
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                     start_i;
  logic [KW-1:0]            k_len_i;
  logic                     a_valid_i;
  logic                     a_ready_o;
  logic [ROWS*DATA_W-1:0]   a_i;
  logic [COLS*DATA_W-1:0]   b_i;
  logic                     c_valid_o;
  logic                     c_ready_i;
  logic [COLS*ACC_W-1:0]    c_o;
  logic [RW-1:0]            c_row_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     ovf_o;

  modport master (
    output start_i, k_len_i, a_valid_i, a_i, b_i, c_ready_i,
    input  a_ready_o, c_valid_o, c_o, c_row_o, busy_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, k_len_i, a_valid_i, a_i, b_i, c_ready_i,
    output a_ready_o, c_valid_o, c_o, c_row_o, busy_o, done_o, ovf_o
  );

endinterface

// File: rtl/systolic_array_seq_pe_acc.sv
// Accumulating PE: a passes east, b passes south, acc += a*b when enabled.
// SYS_ARRAY_SAT_EN selects saturating accumulation; otherwise it wraps.
module pe_acc
  import systolic_array_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_w,
  input  logic signed [DATA_W-1:0] b_n,
  output logic signed [DATA_W-1:0] a_e,
  output logic signed [DATA_W-1:0] b_s,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    acc_nx;

  assign prod   = a_w * b_n;
  assign addend = ACC_W'(prod);

`ifdef SYS_ARRAY_SAT_EN
  logic signed [63:0] s64;
  logic               hit;

  always_comb begin
    hit    = 1'b0;
    s64    = sat_add(64'(acc), 64'(addend), ACC_W, hit);
    acc_nx = ACC_W'(s64);
  end

  assign sat = en & hit;
`else
  assign acc_nx = acc + addend;
  assign sat    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_e <= '0;
      b_s <= '0;
      acc <= '0;
    end else if (clr) begin
      a_e <= '0;
      b_s <= '0;
      acc <= '0;
    end else if (en) begin
      a_e <= a_w;
      b_s <= b_n;
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/systolic_array_seq.sv
// Self-sequencing output-stationary systolic array: skew, accumulate, drain.
// SYS_ARRAY_SAT_EN enables saturating PEs and the sticky ovf_o flag.
module systolic_array_seq
  import systolic_array_seq_pkg::*;
#(
  parameter int ROWS   = ROWS_D,
  parameter int COLS   = COLS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int K_MAX  = K_MAX_D
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  systolic_array_seq_if.slave bus
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS);

  sys_fsm_e      state, state_nx;
  logic [KW-1:0] k_len, beats;
  logic [FW-1:0] fcnt;
  logic [RW-1:0] row;
  logic          done, ovf;
  logic          start_ok, beat, en;
  logic          last_beat, flush_end, row_hs, last_row;
  logic          a_ready, c_valid, busy, sat_any;

  logic signed [DATA_W-1:0] ah    [ROWS][COLS+1];
  logic signed [DATA_W-1:0] bv    [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc_g [ROWS][COLS];
  logic [COLS-1:0]          sat_g [ROWS];
  logic [COLS*ACC_W-1:0]    c_dat;

  assign start_ok  = (state == S_IDLE) & bus.start_i;
  assign beat      = (state == S_LOAD) & bus.a_valid_i;
  assign en        = (state == S_LOAD) | (state == S_FLUSH);
  assign last_beat = beat & ((beats + KW'(1)) == k_len);
  assign flush_end = (state == S_FLUSH) & (fcnt == FW'(ROWS + COLS - 2));
  assign row_hs    = (state == S_DRAIN) & bus.c_ready_i;
  assign last_row  = row_hs & (row == RW'(ROWS - 1));

  always_comb begin
    state_nx = state;
    a_ready  = 1'b0;
    c_valid  = 1'b0;
    busy     = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start_i)
          state_nx = (bus.k_len_i == '0) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: begin
        a_ready = 1'b1;
        if (last_beat) state_nx = S_FLUSH;
      end
      S_FLUSH: if (flush_end) state_nx = S_DRAIN;
      S_DRAIN: begin
        c_valid = 1'b1;
        if (last_row) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      k_len <= '0;
      beats <= '0;
      fcnt  <= '0;
      row   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_row;
      if (start_ok) begin
        k_len <= bus.k_len_i;
        beats <= '0;
        fcnt  <= '0;
        row   <= '0;
      end else begin
        if (beat) beats <= beats + KW'(1);
        if (state == S_FLUSH) fcnt <= fcnt + FW'(1);
        if (row_hs) row <= last_row ? '0 : row + RW'(1);
      end
    end
  end

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < ROWS; i++) sat_any |= |sat_g[i];
  end

`ifdef SYS_ARRAY_SAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       ovf <= 1'b0;
    else if (start_ok) ovf <= 1'b0;
    else if (sat_any)  ovf <= 1'b1;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_any;
  assign ovf        = 1'b0;
`endif

  // Lane i is delayed i cycles so operand k meets its partner at PE(i,j).
  for (genvar i = 0; i < ROWS; i++) begin : g_ska
    logic signed [DATA_W-1:0] inj;
    logic                     unused_e;
    assign inj      = beat ? bus.a_i[i*DATA_W +: DATA_W] : '0;
    assign unused_e = ^ah[i][COLS];
    if (i == 0) begin : g_z
      assign ah[0][0] = inj;
    end else begin : g_d
      logic signed [DATA_W-1:0] dl [i];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int d = 0; d < i; d++) dl[d] <= '0;
        end else if (start_ok) begin
          for (int d = 0; d < i; d++) dl[d] <= '0;
        end else if (en) begin
          dl[0] <= inj;
          for (int d = 1; d < i; d++) dl[d] <= dl[d-1];
        end
      end
      assign ah[i][0] = dl[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skb
    logic signed [DATA_W-1:0] inj;
    logic                     unused_s;
    assign inj      = beat ? bus.b_i[j*DATA_W +: DATA_W] : '0;
    assign unused_s = ^bv[ROWS][j];
    if (j == 0) begin : g_z
      assign bv[0][0] = inj;
    end else begin : g_d
      logic signed [DATA_W-1:0] dl [j];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int d = 0; d < j; d++) dl[d] <= '0;
        end else if (start_ok) begin
          for (int d = 0; d < j; d++) dl[d] <= '0;
        end else if (en) begin
          dl[0] <= inj;
          for (int d = 1; d < j; d++) dl[d] <= dl[d-1];
        end
      end
      assign bv[0][j] = dl[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      pe_acc #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .clr  (start_ok),
        .en   (en),
        .a_w  (ah[i][j]),
        .b_n  (bv[i][j]),
        .a_e  (ah[i][j+1]),
        .b_s  (bv[i+1][j]),
        .acc  (acc_g[i][j]),
        .sat  (sat_g[i][j])
      );
    end
  end

  always_comb begin
    c_dat = '0;
    for (int i = 0; i < ROWS; i++)
      if (row == RW'(i))
        for (int j = 0; j < COLS; j++)
          c_dat[j*ACC_W +: ACC_W] = acc_g[i][j];
  end

  assign bus.a_ready_o = a_ready;
  assign bus.c_valid_o = c_valid;
  assign bus.c_o       = c_dat;
  assign bus.c_row_o   = row;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.ovf_o     = ovf;

endmodule

// File: tb/tb_systolic_array_seq.sv
// Scoreboard bench for systolic_array_seq: 4x4 array, 16-bit accumulators.
// Expected rows come from a reference matrix model queued at tile start.
module tb_systolic_array_seq;
  import systolic_array_seq_pkg::*;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KM = 15;
  localparam int KW = $clog2(KM + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_seq_if #(
    .ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)
  ) bus ();

  systolic_array_seq #(
    .ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic signed [DW-1:0] ma [R][KM];
  logic signed [DW-1:0] mb [KM][C];
  logic [63:0]          sb_q [$];
  logic                 sb_ovf;

  always @(posedge clk) if (bus.done_o === 1'b1) done_cnt++;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_model(input int k);
    logic [63:0]       rowv;
    logic signed [15:0] t;
    longint            a;
    sb_ovf = 1'b0;
    for (int i = 0; i < R; i++) begin
      rowv = '0;
      for (int j = 0; j < C; j++) begin
        a = 0;
        for (int s = 0; s < k; s++) begin
          a += longint'(ma[i][s]) * longint'(mb[s][j]);
`ifdef SYS_ARRAY_SAT_EN
          if (a > 32767) begin
            a = 32767;
            sb_ovf = 1'b1;
          end else if (a < -32768) begin
            a = -32768;
            sb_ovf = 1'b1;
          end
`else
          t = a[15:0];
          a = longint'(t);
`endif
        end
        rowv[j*AW +: AW] = a[15:0];
      end
      sb_q.push_back(rowv);
    end
  endtask

  task automatic feed(input int k, input int vmode, input bit poke);
    int  pat [4] = '{1, 0, 0, 1};
    int  s = 0;
    int  g = 0;
    bit  v, hs;
    while (s < k && g < 100) begin
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = pat[g % 4] != 0;
      else                 v = $urandom_range(0, 1) != 0;
      bus.a_valid_i = v;
      for (int i = 0; i < R; i++) bus.a_i[i*DW +: DW] = ma[i][s];
      for (int j = 0; j < C; j++) bus.b_i[j*DW +: DW] = mb[s][j];
      if (poke) bus.start_i = 1'b1;
      hs = v & bus.a_ready_o;
      @(negedge clk);
      if (hs) s++;
      g++;
    end
    bus.a_valid_i = 1'b0;
    bus.start_i   = 1'b0;
    chk("beats", s, k);
  endtask

  task automatic run_tile(input int k, input int vmode, input bit hold,
                          input bit chain_in, input int chain_k,
                          input bit poke);
    int          d0;
    int          lat;
    logic [63:0] exp;
    d0 = done_cnt;
    push_model(k);
    if (!chain_in) begin
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.k_len_i = KW'(k);
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("busy_on", bus.busy_o, 1);
    end
    if (k == 0) begin
      chk("k0_valid", bus.c_valid_o, 1);
    end else begin
      chk("rdy_on", bus.a_ready_o, 1);
      feed(k, vmode, poke);
      lat = 1;
      while (!bus.c_valid_o && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("flush_lat", lat, R + C);
    end
    for (int r = 0; r < R; r++) begin
      exp = sb_q.pop_front();
      if (poke) bus.start_i = 1'b1;
      if (hold && r == 0) begin
        repeat (3) begin
          bus.c_ready_i = 1'b0;
          @(negedge clk);
          chk("hold_row", bus.c_row_o, 0);
          chk("hold_data", bus.c_o, exp);
        end
      end
      chk("c_valid", bus.c_valid_o, 1);
      chk("c_row", bus.c_row_o, r);
      chk("c_o", bus.c_o, exp);
      if (r == 0) chk("ovf", bus.ovf_o, sb_ovf);
      bus.c_ready_i = 1'b1;
      @(negedge clk);
      bus.c_ready_i = 1'b0;
    end
    bus.start_i = 1'b0;
    chk("done", bus.done_o, 1);
    chk("busy_off", bus.busy_o, 0);
    if (chain_k >= 0) begin
      bus.start_i = 1'b1;
      bus.k_len_i = KW'(chain_k);
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("chain_busy", bus.busy_o, 1);
    end else begin
      @(negedge clk);
      chk("done_pulse", bus.done_o, 0);
    end
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic set_small();
    for (int i = 0; i < R; i++)
      for (int s = 0; s < KM; s++) ma[i][s] = '0;
    for (int s = 0; s < KM; s++)
      for (int j = 0; j < C; j++) mb[s][j] = '0;
    ma[0][0] = 8'sd1; ma[0][1] = 8'sd2;
    ma[1][0] = 8'sd3; ma[1][1] = 8'sd4;
    mb[0][0] = 8'sd5; mb[0][1] = 8'sd6;
    mb[1][0] = 8'sd7; mb[1][1] = 8'sd8;
  endtask

  function automatic logic signed [DW-1:0] pick();
    int unsigned c;
    c = $urandom_range(0, 3);
    if (c == 0) return -8'sd128;
    if (c == 1) return 8'sd127;
    return DW'($urandom);
  endfunction

  task automatic set_rand();
    for (int i = 0; i < R; i++)
      for (int s = 0; s < KM; s++) ma[i][s] = pick();
    for (int s = 0; s < KM; s++)
      for (int j = 0; j < C; j++) mb[s][j] = pick();
  endtask

  initial begin
    int d0;
    bus.start_i   = 1'b0;
    bus.k_len_i   = '0;
    bus.a_valid_i = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.c_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", bus.a_ready_o, 0);
    chk("rst_c_valid", bus.c_valid_o, 0);
    chk("rst_c_o", bus.c_o, 0);
    chk("rst_c_row", bus.c_row_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);
    rst_n = 1'b1;

    set_small();
    run_tile(2, 0, 1'b0, 1'b0, -1, 1'b0);
    run_tile(2, 1, 1'b1, 1'b0, -1, 1'b0);

    repeat (2) begin
      set_rand();
      run_tile(3, 2, 1'b0, 1'b0, -1, 1'b1);
    end

    run_tile(0, 0, 1'b0, 1'b0, -1, 1'b0);

    for (int i = 0; i < R; i++)
      for (int s = 0; s < KM; s++) ma[i][s] = -8'sd128;
    for (int s = 0; s < KM; s++)
      for (int j = 0; j < C; j++) mb[s][j] = -8'sd128;
    run_tile(3, 0, 1'b0, 1'b0, 2, 1'b0);
    set_small();
    run_tile(2, 2, 1'b0, 1'b1, -1, 1'b0);

    set_rand();
    d0 = done_cnt;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(3);
    @(negedge clk);
    bus.start_i = 1'b0;
    feed(3, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_a_ready", bus.a_ready_o, 0);
    chk("abort_c_valid", bus.c_valid_o, 0);
    chk("abort_c_o", bus.c_o, 0);
    chk("abort_c_row", bus.c_row_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_ovf", bus.ovf_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    set_rand();
    run_tile(2, 0, 1'b0, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_seq.md
# systolic_array_seq

Parametrised, self-sequencing output-stationary systolic array for signed integer matrix multiply C = A·B. It accepts unskewed operand vectors over a valid/ready stream, one K-step per beat, and skews them internally. It accumulates K_LEN steps in a ROWS×COLS grid of accumulating PEs, then drains C one row per handshake. It replaces the fixed-size array/drain-channel pair at the compute core of the accelerator, fed by the operand buffers and drained into the result writer.

## Interface
- ROWS, 4, PE rows (≥1); number of A lanes and of C rows
- COLS, 4, PE columns (≥1); number of B lanes and of C columns
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator width (≥2·DATA_W)
- K_MAX, 256, largest supported K; KW = $clog2(K_MAX+1)
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  begin a tile; honoured only in IDLE
- k_len_i  in  KW  K length; sampled with start_i
- a_valid_i  in  1  operand beat valid
- a_ready_o  out  1  operand beat accepted when a_valid_i & a_ready_o
- a_i  in  ROWS×DATA_W  A column k (lane i = A[i][k])
- b_i  in  COLS×DATA_W  B row k (lane j = B[k][j])
- c_valid_o  out  1  result row valid
- c_ready_i  in  1  result row consumed when c_valid_o & c_ready_i
- c_o  out  COLS×ACC_W  C[c_row_o][0..COLS-1]
- c_row_o  out  $clog2(ROWS) (min 1)  index of the row on c_o
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse after the last row handshake
- ovf_o  out  1  sticky saturation flag for the current tile

## Operation
- FSM: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- IDLE: on start_i, latch k_len_i, clear all accumulators, skew registers and ovf_o, and clear the beat counter. If k_len_i=0, go to DRAIN; otherwise go to LOAD.
- LOAD: a_ready_o=1. Each accepted beat increments the beat counter. On the beat that makes count = K_LEN, go to FLUSH.
- The array advances every cycle in LOAD and FLUSH. A cycle without an accepted beat injects zeros on all lanes. Bubbles are therefore harmless.
- Skew: A lane i is delayed i cycles and B lane j is delayed j cycles before entering column 0 / row 0.
- PE(i,j): registers a eastward and b southward; acc += sext(a·b). The product is a signed 2·DATA_W value, sign-extended to ACC_W.
- FLUSH: zeros are injected for exactly ROWS+COLS-1 cycles, then the FSM goes to DRAIN.
- DRAIN:
  - c_valid_o=1; c_o = accumulators of row c_row_o, starting at row 0.
  - Each handshake increments c_row_o.
  - The handshake on row ROWS-1 returns the FSM to IDLE and pulses done_o on the following cycle.
  - c_o/c_row_o stay stable while c_valid_o & !c_ready_i.
- start_i outside IDLE is ignored. a_valid_i outside LOAD is ignored (a_ready_o=0).
- Overflow without the macro: accumulation wraps modulo 2^ACC_W, and ovf_o is held 0.

## Timing
- Reset values: a_ready_o=0, c_valid_o=0, c_o=0, c_row_o=0, busy_o=0, done_o=0, ovf_o=0; FSM=IDLE; accumulators, skew and pipeline registers are 0.
- start_i high at cycle 0 → busy_o=1 and a_ready_o=1 from cycle 1.
- Last beat accepted at cycle t → FLUSH spans cycles t+1 … t+ROWS+COLS-1 → c_valid_o=1 from cycle t+ROWS+COLS.
- With K_LEN=0, c_valid_o=1 at cycle 1 and all rows are 0.
- Minimum drain is ROWS cycles with c_ready_i held high. done_o is high at the cycle after the final handshake, when busy_o is already 0.
- A new start_i is accepted in the same cycle done_o is high.
- Reset asserted mid-tile forces the reset values immediately, and no done_o is produced.

## Configuration
- SYS_ARRAY_SAT_EN defined: each PE saturates its accumulator to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any saturation event during the tile sets ovf_o, which stays set until the next start_i or reset.
- SYS_ARRAY_SAT_EN undefined: wrap-around arithmetic, and ovf_o is tied 0.

## Structure
- Shared package: the sys_fsm_e state enum; the default ROWS/COLS/DATA_W/ACC_W/K_MAX constants; and the saturating-add function (used by the PE under SYS_ARRAY_SAT_EN).
- One sub-module, pe_acc: an accumulating PE with a/b pass-through registers, a clear input, an enable input and a saturation-event output.
- Top level: FSM, beat/flush/row counters, skew shift registers, PE grid generate and row-select mux.

## Test plan
- 2×2, DATA_W=8, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats back-to-back, c_ready_i=1 → rows [19,22] then [43,50]; first c_valid_o 4 cycles after the last beat; done_o pulses once.
- Same stimulus with a_valid_i toggled 1,0,0,1 and c_ready_i low for 3 cycles on row 0 → identical results; row 0 held stable; no row skipped or duplicated.
- 4×4, K=3, signed operands -128 and 127 mixed, random bubbles → matches a reference model; K=0 → four zero rows, c_valid_o at cycle 1.
- ACC_W=16, all operands -128, K=3 → with the macro defined: outputs 32767 and ovf_o=1; without it: outputs 49152 mod 2^16 as signed (-16384) and ovf_o=0.
- rst_ni pulsed low during FLUSH, then a new K=2 tile → outputs are reset values at once; new tile results match with no residue from the aborted tile.
- start_i asserted during LOAD/DRAIN → ignored; start_i in the done_o cycle → next tile starts (busy_o=1 next cycle).
